// File: rtl/copy_engine_pkg.sv
// rtl/copy_engine_pkg.sv - shared command types and scheduler state encoding for the copy engine
package copy_engine_pkg;

  // A 4KB page holds this many 64-byte lines; no burst may straddle one.
  localparam int PAGE_LINES = 64;

  typedef logic [63:0] t_cmd_addr;
  // AXI length encoding: beats minus one.
  typedef logic [7:0]  t_cmd_num_lines;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } t_rd_sched_state;

endpackage

// File: rtl/copy_read_burst_tracker.sv
// rtl/copy_read_burst_tracker.sv - FIFO of cumulative burst end marks, retired as read lines come back
module copy_read_burst_tracker #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_mark,
  input  logic [31:0] lines_done,
  output logic        full,
  output logic        empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]   marks [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && !full;
  // A burst is fully returned once the job's completed-line count reaches its end mark.
  assign pop     = !empty && (lines_done >= marks[rd_ptr]);

  // Mark storage; contents only matter between push and pop, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      marks[wr_ptr] <= push_mark;
    end
  end

  // Occupancy and pointers; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/copy_read_scheduler.sv
// rtl/copy_read_scheduler.sv - splits a copy job into page-safe read bursts with line/burst throttling; optional COPY_READ_SCHED_STATS_EN adds job statistics
module copy_read_scheduler
  import copy_engine_pkg::*;
#(
  parameter int ADDR_WIDTH            = 64,
  parameter int MAX_REQS_IN_FLIGHT    = 32,
  parameter int MAX_OUTSTANDING_LINES = 512,
  parameter int LINE_BYTES            = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [31:0]           total_lines,
  input  logic [6:0]            max_burst_lines,
  input  logic [63:0]           num_lines_read,
  output logic                  rd_cmd_enable,
  output logic [ADDR_WIDTH-1:0] rd_cmd_addr,
  output t_cmd_num_lines        rd_cmd_num_lines,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           lines_issued
`ifdef COPY_READ_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_job_cycles,
  output logic [31:0]           stat_throttle_cycles
`endif
);

  localparam int LINE_SHIFT = $clog2(LINE_BYTES);

  t_rd_sched_state       state;
  t_rd_sched_state       state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]           total_q;
  logic [6:0]            max_q;
  logic [63:0]           rd_base;
  logic [31:0]           lines_done;
  logic [31:0]           remaining;
  logic [31:0]           outstanding;
  logic [6:0]            max_eff;
  logic [6:0]            to_page;
  logic [6:0]            burst;
  logic [32:0]           need;
  logic                  fits;
  logic                  issue;
  logic                  drained;
  logic                  trk_full;
  logic                  trk_empty;

  // Modulo-2^64 difference keeps a wrapping engine counter harmless.
  assign lines_done  = 32'(num_lines_read - rd_base);
  assign remaining   = total_q - lines_issued;
  assign outstanding = lines_issued - lines_done;

  // Zero means the full 64-line cap; anything larger is clipped to a page anyway.
  assign max_eff = ((max_q == '0) || (max_q > 7'(PAGE_LINES))) ? 7'(PAGE_LINES) : max_q;
  assign to_page = 7'(PAGE_LINES) - {1'b0, cur_addr[LINE_SHIFT +: 6]};

  // Burst length is the smallest of the cap, the distance to the page end and what is left.
  always_comb begin
    burst = max_eff;
    if (to_page < burst) begin
      burst = to_page;
    end
    if (remaining < 32'(burst)) begin
      burst = remaining[6:0];
    end
  end

  assign need    = {1'b0, outstanding} + 33'(burst);
  assign fits    = (need <= 33'(MAX_OUTSTANDING_LINES));
  assign issue   = (state == ISSUE) && (remaining != '0) && fits && !trk_full;
  assign drained = (lines_done == total_q) && trk_empty;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; an empty job passes from ISSUE directly to DONE when nothing is pending.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (remaining == '0) begin
          state_nxt = drained ? DONE : DRAIN;
        end else if (issue && (32'(burst) == remaining)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Job latch at start, burst address/count advance and registered command outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_addr         <= '0;
      total_q          <= '0;
      max_q            <= '0;
      rd_base          <= '0;
      lines_issued     <= '0;
      rd_cmd_enable    <= 1'b0;
      rd_cmd_addr      <= '0;
      rd_cmd_num_lines <= '0;
    end else begin
      rd_cmd_enable <= issue;
      if ((state == IDLE) && start) begin
        cur_addr     <= src_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
        total_q      <= total_lines;
        max_q        <= max_burst_lines;
        rd_base      <= num_lines_read;
        lines_issued <= '0;
      end else if (issue) begin
        rd_cmd_addr      <= cur_addr;
        rd_cmd_num_lines <= 8'(burst - 7'd1);
        cur_addr         <= cur_addr + (ADDR_WIDTH'(burst) << LINE_SHIFT);
        lines_issued     <= lines_issued + 32'(burst);
      end
    end
  end

  copy_read_burst_tracker #(
    .DEPTH(MAX_REQS_IN_FLIGHT)
  ) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .push      (issue),
    .push_mark (lines_issued + 32'(burst)),
    .lines_done(lines_done),
    .full      (trk_full),
    .empty     (trk_empty)
  );

`ifdef COPY_READ_SCHED_STATS_EN
  // Saturating job-length and throttle counters, frozen once the job is back in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_job_cycles      <= '0;
      stat_throttle_cycles <= '0;
    end else if ((state == IDLE) && start) begin
      stat_job_cycles      <= '0;
      stat_throttle_cycles <= '0;
    end else begin
      if ((state != IDLE) && (stat_job_cycles != '1)) begin
        stat_job_cycles <= stat_job_cycles + 32'd1;
      end
      if ((state == ISSUE) && (remaining != '0) && !issue && (stat_throttle_cycles != '1)) begin
        stat_throttle_cycles <= stat_throttle_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
